wash_phase_timer: RTL and testbench
===================================

Name: wash_phase_timer

Overview:
- Sits directly upstream of automatic_washing_machine.
- Turns the machine's actuator outputs (fill_value_on, drain_value_on, motor_on, soap_wash, water_wash) and a raw digitised water-level reading into the status inputs that controller consumes: filled, drained, cycle_timeout, spin_timeout.
- Replaces hand-driven bench stimulus with timed, level-qualified behaviour.

Parameters:
- LEVEL_W, 8, width of water-level sample.
- FULL_LEVEL, 200, level at or above which filled asserts.
- EMPTY_LEVEL, 10, level at or below which drained asserts.
- HYST, 8, hysteresis band for both thresholds.
- TICK_DIV, 1000, clocks per timer tick (>=2).
- WASH_TICKS, 600, soap-wash duration in ticks.
- RINSE_TICKS, 300, water-wash (rinse) duration in ticks.
- SPIN_TICKS, 400, spin duration in ticks.
- FILL_TICKS, 900, fill watchdog limit in ticks (optional feature only).
- CNT_W, 16, tick counter width; must hold the max of all *_TICKS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fill_value_on  input  1  fill valve command from controller.
- drain_value_on  input  1  drain valve command from controller.
- motor_on  input  1  drum motor command from controller.
- soap_wash  input  1  controller is in soap-wash stage.
- water_wash  input  1  controller is in rinse stage.
- water_level  input  LEVEL_W  unsigned level sample, valid every cycle.
- filled  output  1  tub full, hysteretic.
- drained  output  1  tub empty, hysteretic.
- cycle_timeout  output  1  wash/rinse duration elapsed; level.
- spin_timeout  output  1  spin duration elapsed; level.
- phase  output  3  current phase code, debug.
- fill_fault  output  1  fill watchdog expired (optional feature; tied 0 otherwise).

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is reset.
- Reset values: filled=0, drained=1, cycle_timeout=0, spin_timeout=0, phase=IDLE, fill_fault=0. Prescaler and tick counter are cleared.
- Level outputs are registered, 1-cycle latency.
  - filled sets when water_level>=FULL_LEVEL and clears when water_level<FULL_LEVEL-HYST; otherwise holds.
  - drained sets when water_level<=EMPTY_LEVEL and clears when water_level>EMPTY_LEVEL+HYST; otherwise holds.
  - Threshold arithmetic is done at LEVEL_W+1 bits, so there is no wrap when HYST exceeds a threshold margin.
- Phase decode, registered each clock from the inputs in priority order:
  - motor_on&drain_value_on -> SPIN(4)
  - motor_on&water_wash -> RINSE(3)
  - motor_on -> WASH(2)
  - drain_value_on -> DRAIN(5)
  - fill_value_on -> FILL(1)
  - else IDLE(0)
  - Codes 6 and 7 are unused and decode to IDLE.
- Phase change: on any edge where the decoded phase differs from the phase register, the phase register loads the new phase, the prescaler and tick counter clear, and cycle_timeout and spin_timeout clear in that same edge.
- Prescaler: counts 0..TICK_DIV-1 while the phase is WASH, RINSE, SPIN or FILL. A tick pulse is generated when the prescaler equals TICK_DIV-1; it then wraps to 0.
- Tick counter: increments on each tick and saturates at its target. Targets: WASH=WASH_TICKS, RINSE=RINSE_TICKS, SPIN=SPIN_TICKS, FILL=FILL_TICKS.
- Timeout timing: with phase entry at edge E0, cycle_timeout (WASH/RINSE) or spin_timeout (SPIN) is registered high at edge E0+target*TICK_DIV.
  - It then stays high until the phase changes or reset.
  - Counters freeze once the target is reached.
- soap_wash is used for the phase only when water_wash=0. If soap_wash and water_wash are both 1, RINSE wins.
- IDLE and DRAIN: prescaler and tick counter are held at 0, and both timeouts are 0.
- Reset mid-phase: everything returns to reset values on the next edge. The phase is re-derived from the inputs on the first edge after reset deasserts.

Optional Feature:
- Macro: WASH_FILL_WATCHDOG_EN.
- When defined: in FILL, if the tick counter reaches FILL_TICKS while filled=0, fill_fault is set and stays sticky until reset. A phase change does not clear it.
- When not defined: fill_fault is constant 0, and the FILL phase does not run the prescaler or tick counter.

Test Plan:
- Bench parameters: TICK_DIV=4, WASH_TICKS=3, RINSE_TICKS=2, SPIN_TICKS=5, FILL_TICKS=6, FULL_LEVEL=200, EMPTY_LEVEL=10, HYST=8.
- Reset: hold reset 2 clocks with water_level=0 -> filled=0, drained=1, both timeouts 0, phase=0; all outputs unchanged by clock activity while reset is high.
- Level hysteresis: ramp water_level 0->200 -> filled=1 one cycle after 200 is sampled; drop to 193 -> filled stays 1; drop to 191 -> filled=0. drained clears at 19 and re-sets at 10.
- Wash timing: motor_on=1, soap_wash=1 -> phase=2; cycle_timeout high exactly 12 clocks after the phase-entry edge. Hold motor_on 20 more clocks -> cycle_timeout stays 1. Drop motor_on -> cycle_timeout 0 the next edge.
- Spin and simultaneity: motor_on=1, drain_value_on=1, water_wash=1 -> phase=4 (SPIN wins); spin_timeout after 20 clocks, cycle_timeout stays 0. Toggling drain_value_on off for 1 cycle at clock 10 -> phase=3 and spin count restarts; spin_timeout 20 clocks after re-entry.
- Reset mid-operation: assert reset at clock 7 of WASH -> timeouts 0 and counters cleared. Release with motor_on still 1 -> cycle_timeout 12 clocks after the re-entry edge.
- Watchdog (macro defined): fill_value_on=1, water_level=50 -> fill_fault=1 at 24 clocks and stays 1 after fill_value_on=0. With the macro undefined -> fill_fault stays 0.

Source files
------------

// File: rtl/wash_phase_if.sv
// Controller-to-timer bundle: actuator commands and the raw level sample in,
// status flags for automatic_washing_machine out.
interface wash_phase_if #(
   parameter int unsigned LEVEL_W = 8
);
   logic               fill_value_on;
   logic               drain_value_on;
   logic               motor_on;
   logic               soap_wash;
   logic               water_wash;
   logic [LEVEL_W-1:0] water_level;
   logic               filled;
   logic               drained;
   logic               cycle_timeout;
   logic               spin_timeout;
   logic [2:0]         phase;
   logic               fill_fault;

   modport master (
      output fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, water_level,
      input  filled, drained, cycle_timeout, spin_timeout, phase, fill_fault
   );

   modport slave (
      input  fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, water_level,
      output filled, drained, cycle_timeout, spin_timeout, phase, fill_fault
   );
endinterface

// File: rtl/wash_phase_timer.sv
// Derives filled/drained/cycle_timeout/spin_timeout from actuator commands and level.
// Optional fill watchdog (fill_fault) enabled by defining WASH_FILL_WATCHDOG_EN.
module wash_phase_timer #(
   parameter int unsigned LEVEL_W     = 8,
   parameter int unsigned FULL_LEVEL  = 200,
   parameter int unsigned EMPTY_LEVEL = 10,
   parameter int unsigned HYST        = 8,
   parameter int unsigned TICK_DIV    = 1000,
   parameter int unsigned WASH_TICKS  = 600,
   parameter int unsigned RINSE_TICKS = 300,
   parameter int unsigned SPIN_TICKS  = 400,
   parameter int unsigned FILL_TICKS  = 900,
   parameter int unsigned CNT_W       = 16
) (
   input  logic         clk,
   input  logic         reset,
   wash_phase_if.slave  bus
);
   localparam int unsigned LW1   = LEVEL_W + 1;
   localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      SPIN  = 3'd4,
      DRAIN = 3'd5
   } phase_t;

   phase_t           phase_q;
   phase_t           phase_d;
   logic [PRE_W-1:0] presc_q;
   logic [CNT_W-1:0] tick_cnt_q;
   logic [CNT_W-1:0] target;
   logic [LW1-1:0]   lvl;
   logic             filled_q;
   logic             drained_q;
   logic             cycle_to_q;
   logic             spin_to_q;
   logic             fill_fault_q;
   logic             run;
   logic             tick;
   logic             hit;

   assign lvl = {1'b0, bus.water_level};

   // soap_wash selects the same WASH phase as a bare motor_on; water_wash takes priority.
   always_comb begin
      phase_d = IDLE;
      if (bus.motor_on && bus.drain_value_on)  phase_d = SPIN;
      else if (bus.motor_on && bus.water_wash) phase_d = RINSE;
      else if (bus.motor_on && bus.soap_wash)  phase_d = WASH;
      else if (bus.motor_on)                   phase_d = WASH;
      else if (bus.drain_value_on)             phase_d = DRAIN;
      else if (bus.fill_value_on)              phase_d = FILL;
   end

   always_comb begin
      target = '0;
      run    = 1'b0;
      case (phase_q)
         WASH:  begin target = CNT_W'(WASH_TICKS);  run = 1'b1; end
         RINSE: begin target = CNT_W'(RINSE_TICKS); run = 1'b1; end
         SPIN:  begin target = CNT_W'(SPIN_TICKS);  run = 1'b1; end
         FILL: begin
            target = CNT_W'(FILL_TICKS);
`ifdef WASH_FILL_WATCHDOG_EN
            run = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // hit is true on the edge the counter lands on its target and while it stays frozen there.
   assign tick = run && (tick_cnt_q < target) && (presc_q == PRE_W'(TICK_DIV - 1));
   assign hit  = (tick_cnt_q >= target) || (tick && (tick_cnt_q == target - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q      <= IDLE;
         presc_q      <= '0;
         tick_cnt_q   <= '0;
         filled_q     <= 1'b0;
         drained_q    <= 1'b1;
         cycle_to_q   <= 1'b0;
         spin_to_q    <= 1'b0;
         fill_fault_q <= 1'b0;
      end else begin
         if (lvl >= LW1'(FULL_LEVEL))
            filled_q <= 1'b1;
         else if (lvl + LW1'(HYST) < LW1'(FULL_LEVEL))
            filled_q <= 1'b0;

         if (lvl <= LW1'(EMPTY_LEVEL))
            drained_q <= 1'b1;
         else if (lvl > LW1'(EMPTY_LEVEL + HYST))
            drained_q <= 1'b0;

         if (phase_d != phase_q) begin
            phase_q    <= phase_d;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            cycle_to_q <= 1'b0;
            spin_to_q  <= 1'b0;
         end else begin
            if (!run) begin
               presc_q    <= '0;
               tick_cnt_q <= '0;
            end else if (tick) begin
               presc_q    <= '0;
               tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end else if (tick_cnt_q < target) begin
               presc_q <= presc_q + PRE_W'(1);
            end
            cycle_to_q <= run && hit && ((phase_q == WASH) || (phase_q == RINSE));
            spin_to_q  <= run && hit && (phase_q == SPIN);
`ifdef WASH_FILL_WATCHDOG_EN
            if ((phase_q == FILL) && hit && !filled_q)
               fill_fault_q <= 1'b1;
`endif
         end
      end
   end

   assign bus.filled        = filled_q;
   assign bus.drained       = drained_q;
   assign bus.cycle_timeout = cycle_to_q;
   assign bus.spin_timeout  = spin_to_q;
   assign bus.phase         = phase_q;
   assign bus.fill_fault    = fill_fault_q;
endmodule

// File: tb/tb_wash_phase_timer.sv
module tb_wash_phase_timer;
  localparam int S_FILLED  = 0;
  localparam int S_DRAINED = 1;
  localparam int S_CYC     = 2;
  localparam int S_SPIN    = 3;
  localparam int S_PHASE   = 4;
  localparam int S_FAULT   = 5;

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } chk_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  chk_t sb[$];

  wash_phase_if #(.LEVEL_W(8)) bus ();

  wash_phase_timer #(
    .LEVEL_W    (8),
    .FULL_LEVEL (200),
    .EMPTY_LEVEL(10),
    .HYST       (8),
    .TICK_DIV   (4),
    .WASH_TICKS (3),
    .RINSE_TICKS(2),
    .SPIN_TICKS (5),
    .FILL_TICKS (6),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act_of(input int sel);
    case (sel)
      S_FILLED:  return int'(bus.filled);
      S_DRAINED: return int'(bus.drained);
      S_CYC:     return int'(bus.cycle_timeout);
      S_SPIN:    return int'(bus.spin_timeout);
      S_PHASE:   return int'(bus.phase);
      default:   return int'(bus.fill_fault);
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sel, input int exp, input string name);
    chk_t c;
    c.cyc  = cyc + dly;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic expect_reset_vals(input int dly, input string tag);
    expect_at(dly, S_FILLED,  0, {tag, "_filled"});
    expect_at(dly, S_DRAINED, 1, {tag, "_drained"});
    expect_at(dly, S_CYC,     0, {tag, "_cycle_to"});
    expect_at(dly, S_SPIN,    0, {tag, "_spin_to"});
    expect_at(dly, S_PHASE,   0, {tag, "_phase"});
    expect_at(dly, S_FAULT,   0, {tag, "_fault"});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmds(input logic fill, input logic drain, input logic motor,
                      input logic soap, input logic rinse);
    bus.fill_value_on  = fill;
    bus.drain_value_on = drain;
    bus.motor_on       = motor;
    bus.soap_wash      = soap;
    bus.water_wash     = rinse;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_checks++;
        if (act_of(sb[i].sel) == sb[i].exp)
          n_pass++;
        else
          $display("FAIL %s: got %0d expected %0d (edge %0d)",
                   sb[i].name, act_of(sb[i].sel), sb[i].exp, cyc);
        sb.delete(i);
      end
    end
  end

  int lv_tab [10] = '{18, 19, 150, 199, 200, 193, 192, 191, 11, 10};
  int lv_sel [10] = '{S_DRAINED, S_DRAINED, S_FILLED, S_FILLED, S_FILLED,
                      S_FILLED, S_FILLED, S_FILLED, S_DRAINED, S_DRAINED};
  int lv_exp [10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus.water_level = 8'd0;
    cmds(0, 0, 0, 0, 0);

    step(1);
    expect_reset_vals(0, "rst0");
    n_checks++;
    if (bus.phase === 3'd0 && bus.drained === 1'b1 && bus.filled === 1'b0)
      n_pass++;
    else
      $display("FAIL direct_rst: phase=%0d drained=%0b filled=%0b",
               bus.phase, bus.drained, bus.filled);
    cmds(1, 1, 1, 1, 1);
    bus.water_level = 8'd250;
    expect_reset_vals(1, "rst_hold");
    step(1);
    n_checks++;
    if (bus.filled === 1'b0 && bus.cycle_timeout === 1'b0 && bus.spin_timeout === 1'b0)
      n_pass++;
    else
      $display("FAIL direct_rst_hold: filled=%0b cyc=%0b spin=%0b",
               bus.filled, bus.cycle_timeout, bus.spin_timeout);
    cmds(0, 0, 0, 0, 0);
    bus.water_level = 8'd0;
    reset = 1'b0;
    expect_at(1, S_PHASE,   0, "rel_phase");
    expect_at(1, S_DRAINED, 1, "rel_drained");
    step(1);

    for (int unsigned i = 0; i < 10; i++) begin
      bus.water_level = 8'(lv_tab[i]);
      expect_at(1, lv_sel[i], lv_exp[i], $sformatf("lvl_%0d", lv_tab[i]));
      step(1);
    end

    cmds(0, 0, 1, 1, 0);
    expect_at(1,  S_PHASE, 2, "wash_phase");
    expect_at(12, S_CYC,   0, "wash_early");
    expect_at(13, S_CYC,   1, "wash_to");
    expect_at(13, S_SPIN,  0, "wash_spin0");
    step(13);
    n_checks++;
    if (bus.cycle_timeout === 1'b1 && bus.phase === 3'd2)
      n_pass++;
    else
      $display("FAIL direct_wash_to: cyc=%0b phase=%0d", bus.cycle_timeout, bus.phase);
    expect_at(20, S_CYC, 1, "wash_hold");
    step(20);
    cmds(0, 0, 0, 0, 0);
    expect_at(1, S_CYC,   0, "wash_drop");
    expect_at(1, S_PHASE, 0, "wash_idle");
    step(3);

    cmds(0, 0, 1, 1, 1);
    expect_at(1, S_PHASE, 3, "rinse_phase");
    expect_at(8, S_CYC,   0, "rinse_early");
    expect_at(9, S_CYC,   1, "rinse_to");
    step(9);
    cmds(0, 0, 0, 0, 0);
    step(2);

    cmds(0, 1, 1, 0, 1);
    expect_at(1,  S_PHASE, 4, "spin_phase");
    expect_at(20, S_SPIN,  0, "spin_early");
    expect_at(21, S_SPIN,  1, "spin_to");
    expect_at(21, S_CYC,   0, "spin_cyc0");
    step(21);
    n_checks++;
    if (bus.spin_timeout === 1'b1 && bus.cycle_timeout === 1'b0)
      n_pass++;
    else
      $display("FAIL direct_spin_to: spin=%0b cyc=%0b", bus.spin_timeout, bus.cycle_timeout);
    cmds(0, 0, 0, 0, 0);
    step(2);

    cmds(0, 1, 1, 0, 1);
    step(10);
    cmds(0, 0, 1, 0, 1);
    expect_at(1, S_PHASE, 3, "glitch_rinse");
    step(1);
    cmds(0, 1, 1, 0, 1);
    expect_at(1,  S_PHASE, 4, "reentry_spin");
    expect_at(11, S_SPIN,  0, "restart_mid");
    expect_at(20, S_SPIN,  0, "restart_early");
    expect_at(21, S_SPIN,  1, "restart_to");
    step(21);
    cmds(0, 0, 0, 0, 0);
    step(2);

    cmds(0, 1, 0, 0, 0);
    expect_at(1,  S_PHASE, 5, "drain_phase");
    expect_at(15, S_CYC,   0, "drain_cyc0");
    expect_at(15, S_SPIN,  0, "drain_spin0");
    step(15);
    cmds(0, 0, 0, 0, 0);
    step(2);

    cmds(0, 0, 1, 1, 0);
    step(7);
    reset = 1'b1;
    expect_at(1, S_PHASE, 0, "midrst_phase");
    expect_at(1, S_CYC,   0, "midrst_cyc");
    step(1);
    reset = 1'b0;
    expect_at(1,  S_PHASE, 2, "midrst_reentry");
    expect_at(12, S_CYC,   0, "midrst_early");
    expect_at(13, S_CYC,   1, "midrst_to");
    step(13);
    cmds(0, 0, 0, 0, 0);
    step(2);

    bus.water_level = 8'd50;
    cmds(1, 0, 0, 0, 0);
    expect_at(1, S_PHASE, 1, "fill_phase");
`ifdef WASH_FILL_WATCHDOG_EN
    expect_at(24, S_FAULT, 0, "wd_early");
    expect_at(25, S_FAULT, 1, "wd_fault");
`else
    expect_at(25, S_FAULT, 0, "wd_off");
`endif
    expect_at(25, S_CYC, 0, "fill_cyc0");
    step(25);
    cmds(0, 0, 0, 0, 0);
    expect_at(1, S_PHASE, 0, "fill_exit");
`ifdef WASH_FILL_WATCHDOG_EN
    expect_at(3, S_FAULT, 1, "wd_sticky");
`else
    expect_at(3, S_FAULT, 0, "wd_off_after");
`endif
    step(5);
    n_checks++;
`ifdef WASH_FILL_WATCHDOG_EN
    if (bus.fill_fault === 1'b1 && bus.phase === 3'd0)
`else
    if (bus.fill_fault === 1'b0 && bus.phase === 3'd0)
`endif
      n_pass++;
    else
      $display("FAIL direct_fault_end: fault=%0b phase=%0d", bus.fill_fault, bus.phase);

    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s: got unchecked expected edge %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
